mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: the fetch stage (IF) and the memory stage (DM: LDD/STD/PUSH/POP/CALL/RET/interrupt push).
- Sequences each access over a parameterised number of wait states and returns read data with a valid pulse.
- Drives the stall signals that hold the PC/IF_ID and the EX/MEM pipeline registers while their access is outstanding.
- Data accesses win by default; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WAIT_STATES, 1, extra cycles the memory needs before mem_rdata is valid (0 allowed).
- STARVE_LIMIT, 4, consecutive DM grants with if_req pending before IF is forced (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: IF request accepted.
- if_rdata  out  DATA_W  fetched byte; held until the next IF read completes.
- if_valid  out  1  one-cycle pulse: if_rdata updated.
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  one-cycle pulse: DM request accepted.
- dm_rdata  out  DATA_W  read data; held until the next DM read completes.
- dm_valid  out  1  one-cycle pulse: DM access complete (reads and writes).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_fetch  out  1  = if_req & ~if_valid (combinational).
- stall_mem  out  1  = dm_req & ~dm_valid (combinational).

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0, owner register cleared. Reset mid-access aborts immediately: mem_en/mem_we drop asynchronously, no valid pulse is produced, and the aborted access is not retried.
- States:
  - IDLE: arbitrates.
  - ACCESS: owner register (IF/DM), latched addr/we/wdata, and a wait counter (width clog2(WAIT_STATES+1), minimum 1 bit).
- IDLE arbitration, combinational in the cycle:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant DM unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - The selected gnt pulses. On the clock edge, owner/addr/we/wdata are latched (IF is always a read, we=0), the wait counter loads WAIT_STATES, and the state moves to ACCESS.
- starve_cnt update at each grant:
  - DM granted while if_req=1: increment, saturating at STARVE_LIMIT.
  - IF granted, or DM granted with if_req=0: clear to 0.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers only. Requester inputs are ignored after the grant.
  - Counter > 0: decrement and stay.
  - Counter == 0 (last cycle): for a read, capture mem_rdata into the owner's rdata register; then go to IDLE. The owner's valid pulses in the following cycle, i.e. the first IDLE cycle.
  - mem_we is asserted for the whole ACCESS duration on writes.
- Latency: gnt at cycle N; mem_en high cycles N+1 .. N+1+WAIT_STATES; valid at N+2+WAIT_STATES.
- Throughput: the IDLE cycle that carries valid may grant the next request. Back-to-back accesses therefore take WAIT_STATES+2 cycles each.
- A requester whose valid is high in the current cycle is excluded from arbitration in that cycle. This prevents a stale re-grant before the pipeline advances.
- A requester dropping its req after grant: the access still completes and valid still pulses. Dropping before grant: no effect.
- Outside ACCESS, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
- The non-owner's rdata register is never modified.

Test Plan:
- Reset: assert rst mid-ACCESS with WAIT_STATES=1 -> mem_en=0 in the same cycle; if_valid/dm_valid stay 0; after release, an IF req at 0x10 is granted in the first IDLE cycle.
- Single IF read: WAIT_STATES=1, if_addr=0x20, memory returns 0xA5 -> if_gnt at N, mem_en N+1..N+2, if_valid at N+3 with if_rdata=0xA5; stall_fetch high N..N+2, low at N+3.
- Simultaneous requests: IF 0x05 and DM write 0x80 <- 0x3C -> dm_gnt first; mem_we=1, mem_addr=0x80, mem_wdata=0x3C; dm_valid pulses; IF granted in that same IDLE cycle.
- Starvation: STARVE_LIMIT=4, if_req held, dm_req re-asserted after each dm_valid -> exactly 4 DM grants, then if_gnt on the 5th arbitration; starve_cnt returns to 0.
- WAIT_STATES=0, DM read 0x7F returning 0x11 -> mem_en for one cycle, dm_valid at N+2, dm_rdata=0x11; if_rdata unchanged.
- Requester withdraws after grant: dm_req dropped at N+1 -> access still runs, dm_valid still pulses at N+2+WAIT_STATES, and no spurious second grant occurs.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between the fetch stage and the
// memory stage, sequencing each access over WAIT_STATES extra cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_mem
);

  localparam int WAIT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic                grant_if, grant_dm;
  logic                if_elig, dm_elig;

  // A requester whose valid is showing this cycle has not advanced yet, so its
  // request is stale and must not be granted again.
  assign if_elig = if_req & ~if_valid_q;
  assign dm_elig = dm_req & ~dm_valid_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_elig && (!if_elig || starve_q != STARVE_W'(STARVE_LIMIT))) begin
          grant_dm = 1'b1;
        end else if (if_elig) begin
          grant_if = 1'b1;
        end

        if (grant_dm) begin
          state_d = ACCESS;
          owner_d = OWN_DM;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          wait_d  = WAIT_W'(WAIT_STATES);
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d  = ACCESS;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wait_d   = WAIT_W'(WAIT_STATES);
          starve_d = '0;
        end
      end

      ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (owner_q == OWN_DM) begin
            dm_valid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_q     <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  // Grants are combinational, so they are masked while reset is held.
  assign if_gnt      = grant_if & ~rst;
  assign dm_gnt      = grant_dm & ~rst;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_valid    = if_valid_q;
  assign dm_valid    = dm_valid_q;
  assign mem_en      = (state_q == ACCESS);
  assign mem_we      = (state_q == ACCESS) & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign stall_fetch = if_req & ~if_valid_q;
  assign stall_mem   = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a
// WAIT_STATES=1 instance plus hand sequences, and a WAIT_STATES=0 instance.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WAIT_STATES=1, STARVE_LIMIT=4
  logic       if_req, dm_req, dm_we;
  logic [7:0] if_addr, dm_addr, dm_wdata;
  logic       if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we;
  logic       stall_fetch, stall_mem;
  logic [7:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  // Instance B: WAIT_STATES=0
  logic       if_req_b, dm_req_b, dm_we_b;
  logic [7:0] if_addr_b, dm_addr_b, dm_wdata_b;
  logic       if_gnt_b, if_valid_b, dm_gnt_b, dm_valid_b, mem_en_b, mem_we_b;
  logic       stall_fetch_b, stall_mem_b;
  logic [7:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b), .if_rdata(if_rdata_b),
    .if_valid(if_valid_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b), .dm_wdata(dm_wdata_b),
    .dm_gnt(dm_gnt_b), .dm_rdata(dm_rdata_b), .dm_valid(dm_valid_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .stall_fetch(stall_fetch_b), .stall_mem(stall_mem_b)
  );

  // Memory model: fixed contents plus one tracked write location for instance A.
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h20:   rom = 8'hA5;
      8'h05:   rom = 8'h5A;
      8'h40:   rom = 8'hC3;
      8'h41:   rom = 8'h96;
      8'h10:   rom = 8'h77;
      8'h7F:   rom = 8'h11;
      default: rom = a ^ 8'hFF;
    endcase
  endfunction

  logic       wr_valid = 1'b0;
  logic [7:0] wr_addr  = 8'h00;
  logic [7:0] wr_data  = 8'h00;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  assign mem_rdata   = (wr_valid && mem_addr == wr_addr) ? wr_data : rom(mem_addr);
  assign mem_rdata_b = rom(mem_addr_b);

  typedef struct {
    logic       if_req;
    logic [7:0] if_addr;
    logic       dm_req;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       exp_if_gnt;
    logic       exp_if_valid;
    logic       exp_dm_gnt;
    logic       exp_dm_valid;
    logic       exp_mem_en;
    logic       exp_mem_we;
    logic [7:0] exp_mem_addr;
    logic [7:0] exp_mem_wdata;
    logic       exp_stall_fetch;
    logic       exp_stall_mem;
    logic [7:0] exp_if_rdata;
    logic [7:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic ir, input logic [7:0] ia, input logic dr,
                               input logic dw, input logic [7:0] da, input logic [7:0] dd);
    @(negedge clk);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    #1;
  endtask

  task automatic applyStimulusB(input logic ir, input logic [7:0] ia, input logic dr,
                                input logic [7:0] da);
    @(negedge clk);
    if_req_b = ir; if_addr_b = ia; dm_req_b = dr; dm_we_b = 1'b0; dm_addr_b = da; dm_wdata_b = 8'h00;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_req_b = 0; if_addr_b = 0; dm_req_b = 0; dm_we_b = 0; dm_addr_b = 0; dm_wdata_b = 0;

    // Cycle-by-cycle table: single IF read of 0x20, then IF 0x05 racing a DM write 0x80<-0x3C.
    //          ir  ia     dr  dw  da     dd      ig  iv  dg  dv  en  we  ma     mwd    sf  sm  ird    drd
    vecs[0]  = '{1, 8'h20, 0,  0,  8'h00, 8'h00,  1,  0,  0,  0,  0,  0,  8'h00, 8'h00, 1,  0,  8'h00, 8'h00};
    vecs[1]  = '{1, 8'h20, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  1,  0,  8'h20, 8'h00, 1,  0,  8'h00, 8'h00};
    vecs[2]  = '{1, 8'h20, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  1,  0,  8'h20, 8'h00, 1,  0,  8'h00, 8'h00};
    vecs[3]  = '{1, 8'h20, 0,  0,  8'h00, 8'h00,  0,  1,  0,  0,  0,  0,  8'h20, 8'h00, 0,  0,  8'hA5, 8'h00};
    vecs[4]  = '{0, 8'h00, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  0,  0,  8'h20, 8'h00, 0,  0,  8'hA5, 8'h00};
    vecs[5]  = '{1, 8'h05, 1,  1,  8'h80, 8'h3C,  0,  0,  1,  0,  0,  0,  8'h20, 8'h00, 1,  1,  8'hA5, 8'h00};
    vecs[6]  = '{1, 8'h05, 1,  1,  8'h80, 8'h3C,  0,  0,  0,  0,  1,  1,  8'h80, 8'h3C, 1,  1,  8'hA5, 8'h00};
    vecs[7]  = '{1, 8'h05, 1,  1,  8'h80, 8'h3C,  0,  0,  0,  0,  1,  1,  8'h80, 8'h3C, 1,  1,  8'hA5, 8'h00};
    vecs[8]  = '{1, 8'h05, 1,  1,  8'h80, 8'h3C,  1,  0,  0,  1,  0,  0,  8'h80, 8'h3C, 1,  0,  8'hA5, 8'h00};
    vecs[9]  = '{1, 8'h05, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  1,  0,  8'h05, 8'h3C, 1,  0,  8'hA5, 8'h00};
    vecs[10] = '{1, 8'h05, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  1,  0,  8'h05, 8'h3C, 1,  0,  8'hA5, 8'h00};
    vecs[11] = '{1, 8'h05, 0,  0,  8'h00, 8'h00,  0,  1,  0,  0,  0,  0,  8'h05, 8'h3C, 0,  0,  8'h5A, 8'h00};
    vecs[12] = '{0, 8'h00, 0,  0,  8'h00, 8'h00,  0,  0,  0,  0,  0,  0,  8'h05, 8'h3C, 0,  0,  8'h5A, 8'h00};

    #1;
    checkOutput("reset_mem_en", mem_en, 0);
    checkOutput("reset_if_valid", if_valid, 0);
    checkOutput("reset_dm_valid", dm_valid, 0);
    checkOutput("reset_mem_addr", mem_addr, 8'h00);
    checkOutput("reset_if_rdata", if_rdata, 8'h00);
    checkOutput("reset_dm_rdata", dm_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
                    vecs[i].dm_addr, vecs[i].dm_wdata);
      checkOutput($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].exp_if_gnt);
      checkOutput($sformatf("v%0d_if_valid", i), if_valid, vecs[i].exp_if_valid);
      checkOutput($sformatf("v%0d_dm_gnt", i), dm_gnt, vecs[i].exp_dm_gnt);
      checkOutput($sformatf("v%0d_dm_valid", i), dm_valid, vecs[i].exp_dm_valid);
      checkOutput($sformatf("v%0d_mem_en", i), mem_en, vecs[i].exp_mem_en);
      checkOutput($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_mem_we);
      checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_mem_addr);
      checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_mem_wdata);
      checkOutput($sformatf("v%0d_stall_fetch", i), stall_fetch, vecs[i].exp_stall_fetch);
      checkOutput($sformatf("v%0d_stall_mem", i), stall_mem, vecs[i].exp_stall_mem);
      checkOutput($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
      checkOutput($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].exp_dm_rdata);
    end
    checkOutput("write_addr", wr_addr, 8'h80);
    checkOutput("write_data", wr_data, 8'h3C);

    $display("[TB] requester withdraws after grant");
    applyStimulus(0, 8'h00, 1, 0, 8'h40, 8'h00);
    checkOutput("wd_dm_gnt", dm_gnt, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("wd_mem_en1", mem_en, 1);
    checkOutput("wd_mem_addr", mem_addr, 8'h40);
    checkOutput("wd_stall_mem", stall_mem, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("wd_mem_en2", mem_en, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("wd_dm_valid", dm_valid, 1);
    checkOutput("wd_dm_rdata", dm_rdata, 8'hC3);
    checkOutput("wd_if_rdata_kept", if_rdata, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
      checkOutput($sformatf("wd_no_regrant%0d", i), dm_gnt | mem_en | dm_valid, 0);
    end

    // Both requests present in each arbitration; both drop after the grant.
    $display("[TB] starvation");
    for (int r = 0; r < 4; r++) begin
      applyStimulus(1, 8'h10, 1, 0, 8'h41, 8'h00);
      checkOutput($sformatf("st%0d_dm_gnt", r), dm_gnt, 1);
      checkOutput($sformatf("st%0d_if_gnt", r), if_gnt, 0);
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
      applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
      checkOutput($sformatf("st%0d_dm_valid", r), dm_valid, 1);
      checkOutput($sformatf("st%0d_dm_rdata", r), dm_rdata, 8'h96);
    end
    applyStimulus(1, 8'h10, 1, 0, 8'h41, 8'h00);
    checkOutput("st_forced_if_gnt", if_gnt, 1);
    checkOutput("st_forced_dm_gnt", dm_gnt, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("st_if_mem_addr", mem_addr, 8'h10);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("st_if_valid", if_valid, 1);
    checkOutput("st_if_rdata", if_rdata, 8'h77);
    applyStimulus(1, 8'h10, 1, 0, 8'h41, 8'h00);
    checkOutput("st_cleared_dm_gnt", dm_gnt, 1);
    checkOutput("st_cleared_if_gnt", if_gnt, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("st_cleared_dm_valid", dm_valid, 1);

    $display("[TB] reset during a write access");
    applyStimulus(0, 8'h00, 1, 1, 8'h90, 8'hEE);
    checkOutput("rs_dm_gnt", dm_gnt, 1);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rs_mem_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    checkOutput("rs_mem_en_async", mem_en, 0);
    checkOutput("rs_mem_we_async", mem_we, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rs_dm_valid_held", dm_valid, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h10;
    #1;
    checkOutput("rs_if_gnt_first_idle", if_gnt, 1);
    checkOutput("rs_dm_valid_release", dm_valid, 0);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 8'h00);
    checkOutput("rs_dm_valid_c1", dm_valid, 0);
    applyStimulus(1, 8'h10, 0, 0, 8'h00, 8'h00);
    checkOutput("rs_dm_valid_c2", dm_valid, 0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rs_if_valid", if_valid, 1);
    checkOutput("rs_if_rdata", if_rdata, 8'h77);
    checkOutput("rs_no_write", wr_addr, 8'h80);

    $display("[TB] zero wait states");
    applyStimulusB(1, 8'h20, 0, 8'h00);
    checkOutput("b_if_gnt", if_gnt_b, 1);
    applyStimulusB(0, 8'h00, 0, 8'h00);
    checkOutput("b_if_mem_en", mem_en_b, 1);
    applyStimulusB(0, 8'h00, 0, 8'h00);
    checkOutput("b_if_valid", if_valid_b, 1);
    checkOutput("b_if_rdata", if_rdata_b, 8'hA5);
    applyStimulusB(0, 8'h00, 1, 8'h7F);
    checkOutput("b_dm_gnt", dm_gnt_b, 1);
    applyStimulusB(0, 8'h00, 1, 8'h7F);
    checkOutput("b_dm_mem_en", mem_en_b, 1);
    checkOutput("b_dm_mem_addr", mem_addr_b, 8'h7F);
    checkOutput("b_dm_valid_early", dm_valid_b, 0);
    applyStimulusB(0, 8'h00, 0, 8'h00);
    checkOutput("b_dm_mem_en_off", mem_en_b, 0);
    checkOutput("b_dm_valid", dm_valid_b, 1);
    checkOutput("b_dm_rdata", dm_rdata_b, 8'h11);
    checkOutput("b_if_rdata_kept", if_rdata_b, 8'hA5);
    applyStimulusB(0, 8'h00, 0, 8'h00);
    checkOutput("b_dm_valid_pulse", dm_valid_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
